// File: rtl/chrom_batch_sequencer_if.sv
// Memory port and chromosome-processing handshake bundle for chrom_batch_sequencer.
// Signal names keep the sequencer's point of view (o* driven by the sequencer).
`timescale 1ns/1ps
interface chrom_batch_sequencer_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 16
);
  logic [MEM_ADDR_WIDTH-1:0] oMemAddress;
  logic                      oMemRead;
  logic                      oMemWrite;
  logic [31:0]               oMemWriteData;
  logic [31:0]               iMemReadData;
  logic [991:0]              oConcatedChromDescription;
  logic                      oStartProcessing;
  logic                      iReadyToProcess;
  logic                      iDoneProcessing;
  logic                      oDoneProcessingFeedback;
  logic [255:0]              iErrorSums;

  modport master (
    output oMemAddress, oMemRead, oMemWrite, oMemWriteData,
    output oConcatedChromDescription, oStartProcessing, oDoneProcessingFeedback,
    input  iMemReadData, iReadyToProcess, iDoneProcessing, iErrorSums
  );

  modport slave (
    input  oMemAddress, oMemRead, oMemWrite, oMemWriteData,
    input  oConcatedChromDescription, oStartProcessing, oDoneProcessingFeedback,
    output iMemReadData, iReadyToProcess, iDoneProcessing, iErrorSums
  );
endinterface

// File: rtl/chrom_batch_sequencer.sv
// Batch initiator: loads 31-word chromosome descriptions from RAM, runs the
// start/ready/done/feedback handshake, and writes 8 error sums back per chromosome.
`timescale 1ns/1ps
module chrom_batch_sequencer #(
  parameter int unsigned               MEM_ADDR_WIDTH = 16,
  parameter logic [MEM_ADDR_WIDTH-1:0] CHROM_BASE     = '0,
  parameter logic [MEM_ADDR_WIDTH-1:0] RESULT_BASE    = MEM_ADDR_WIDTH'(16'h8000),
  parameter logic [31:0]               TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic                    iClock,
  input  logic                    iReset_n,
  input  logic                    iStart,
  input  logic [7:0]              iNumChroms,
  output logic                    oBusy,
  output logic                    oDone,
  output logic                    oError,
  output logic [7:0]              oChromIndex,
  output logic [2:0]              oDbgState,
  chrom_batch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_READY, S_WAIT_DONE, S_ACK, S_WRITE, S_FINISH
  } state_e;

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic                      start_q, start_d;
  logic                      fb_q, fb_d;
  logic [7:0]                idx_q, idx_d;
  logic [7:0]                count_q, count_d;
  logic [MEM_ADDR_WIDTH-1:0] rdptr_q, rdptr_d;
  logic [MEM_ADDR_WIDTH-1:0] wrptr_q, wrptr_d;
  logic [4:0]                step_q, step_d;
  logic [31:0]               tmo_q, tmo_d;
  logic [991:0]              desc_q, desc_d;
  logic [255:0]              sums_q, sums_d;

  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_read;
  logic                      mem_write;
  logic [31:0]               mem_wdata;
  logic [4:0]                desc_slot;
  logic [9:0]                desc_base;
  logic [7:0]                sum_base;
  logic                      tmo_hit;

  // Read data lags its strobe by one cycle, so step k captures the word for slot k-1.
  assign desc_slot = step_q - 5'd1;
  assign desc_base = {desc_slot, 5'd0};
  assign sum_base  = {step_q[2:0], 5'd0};
  assign tmo_hit   = (tmo_q + 32'd1) == TIMEOUT_CYCLES;

  // Handshake: start is held from ready-seen until done-seen; feedback is held
  // from done-seen until done drops; the two are never high together.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    start_d   = start_q;
    fb_d      = fb_q;
    idx_d     = idx_q;
    count_d   = count_q;
    rdptr_d   = rdptr_q;
    wrptr_d   = wrptr_q;
    step_d    = step_q;
    tmo_d     = tmo_q;
    desc_d    = desc_q;
    sums_d    = sums_q;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (iStart && !done_q) begin
          busy_d  = 1'b1;
          error_d = 1'b0;
          idx_d   = '0;
          count_d = iNumChroms;
          rdptr_d = CHROM_BASE;
          wrptr_d = RESULT_BASE;
          step_d  = '0;
          state_d = (iNumChroms == 8'd0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (step_q != 5'd31) begin
          mem_read = 1'b1;
          mem_addr = rdptr_q;
          rdptr_d  = rdptr_q + MEM_ADDR_WIDTH'(1);
        end
        if (step_q != 5'd0) begin
          desc_d[desc_base +: 32] = bus.iMemReadData;
        end
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) begin
          step_d  = '0;
          tmo_d   = '0;
          state_d = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (bus.iReadyToProcess) begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          start_d = 1'b0;
          fb_d    = 1'b0;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.iDoneProcessing) begin
          sums_d  = bus.iErrorSums;
          start_d = 1'b0;
          fb_d    = 1'b1;
          state_d = S_ACK;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          start_d = 1'b0;
          fb_d    = 1'b0;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_ACK: begin
        if (!bus.iDoneProcessing) begin
          fb_d    = 1'b0;
          step_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = wrptr_q;
        mem_wdata = sums_q[sum_base +: 32];
        wrptr_d   = wrptr_q + MEM_ADDR_WIDTH'(1);
        step_d    = step_q + 5'd1;
        if (step_q == 5'd7) begin
          step_d  = '0;
          idx_d   = idx_q + 8'd1;
          state_d = ((idx_q + 8'd1) == count_q) ? S_FINISH : S_LOAD;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      start_q <= 1'b0;
      fb_q    <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
      rdptr_q <= '0;
      wrptr_q <= '0;
      step_q  <= '0;
      tmo_q   <= '0;
      desc_q  <= '0;
      sums_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      start_q <= start_d;
      fb_q    <= fb_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      rdptr_q <= rdptr_d;
      wrptr_q <= wrptr_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      desc_q  <= desc_d;
      sums_q  <= sums_d;
    end
  end

  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oError      = error_q;
  assign oChromIndex = idx_q;
  assign oDbgState   = state_q;

  assign bus.oMemAddress               = mem_addr;
  assign bus.oMemRead                  = mem_read;
  assign bus.oMemWrite                 = mem_write;
  assign bus.oMemWriteData             = mem_wdata;
  assign bus.oConcatedChromDescription = desc_q;
  assign bus.oStartProcessing          = start_q;
  assign bus.oDoneProcessingFeedback   = fb_q;

endmodule
